// File: rtl/vry_bp_pkg.sv
// vry_bp_pkg: shared state encoding, record layout and road-count clamp
package vry_bp_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_e;
  localparam int CYCLE_W = 8;
  function automatic int rec_width(int road_w, int cnt_w);
    return road_w + CYCLE_W + cnt_w;
  endfunction
  function automatic int clamp_road(int num, int road_max);
    return num == 0 ? 1 : (num > road_max ? road_max : num);
  endfunction
endpackage

// File: rtl/vry_bp_fifo.sv
// vry_bp_fifo: first-word-fall-through record FIFO with simultaneous push/pop
module vry_bp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         wr_en_i,
  input  logic         rd_en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  // storage needs no reset: empty_o hides stale entries
  always_ff @(posedge clk_i)
    if (wr_en_i) mem_q[wr_q[AW-1:0]] <= din_i;
  // read/write pointers with wrap bit to tell full from empty
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en_i) wr_q <= wr_q + 1'b1;
      if (rd_en_i) rd_q <= rd_q + 1'b1;
    end
endmodule

// File: rtl/vry_bottle_print_mc.sv
// vry_bottle_print_mc: round-robin multi-road bottle tracker with print-record FIFO
module vry_bottle_print_mc
  import vry_bp_pkg::*;
#(
  parameter int ROAD_MAX   = 16,
  parameter int ROAD_W     = 8,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk_100,
  input  logic               nRST,
  input  logic               dianyan_en,
  input  logic               b_p_clr,
  input  logic               valid_edge_f1,
  input  logic [ROAD_W-1:0]  b_p_road_num,
  input  logic [CYCLE_W-1:0] b_p_cycle_num,
  output logic [ROAD_W-1:0]  road_sel,
  output logic [CYCLE_W-1:0] cycle_idx,
  output logic               batch_done,
  output logic               busy,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [ROAD_W-1:0]  rec_road,
  output logic [CYCLE_W-1:0] rec_cycle,
  output logic [CNT_W-1:0]   rec_seq,
  output logic               rec_ovf,
  input  logic [ROAD_W-1:0]  cnt_rd_addr,
  output logic [CNT_W-1:0]   cnt_rd_data
);
  localparam int REC_W = rec_width(ROAD_W, CNT_W);
  state_e             state_q, state_d;
  logic [ROAD_W-1:0]  road_last_q, road_last_d, road_sel_q, road_sel_d;
  logic [CYCLE_W-1:0] cycle_num_q, cycle_num_d, cycle_idx_q, cycle_idx_d, cycle_inc;
  logic [CNT_W-1:0]   seq_q, seq_d, cnt_rd_q, cnt_rd_d;
  logic               batch_done_q, batch_done_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q [ROAD_MAX];
  logic               edge_acc, pop, push, fifo_full, fifo_empty;
  logic [REC_W-1:0]   rec_din, rec_dout;
  assign edge_acc = state_q == S_RUN && dianyan_en && valid_edge_f1 && !b_p_clr;
  assign pop      = !fifo_empty && rec_ready;
  assign push     = edge_acc && (!fifo_full || pop);
  assign rec_din  = {road_sel_q, cycle_idx_q, seq_d};
  // next state, road/cycle sequencing, config latch and overflow flag
  always_comb begin
    state_d      = state_q;
    road_last_d  = road_last_q;
    cycle_num_d  = cycle_num_q;
    road_sel_d   = road_sel_q;
    cycle_idx_d  = cycle_idx_q;
    seq_d        = seq_q;
    batch_done_d = 1'b0;
    ovf_d        = ovf_q | (edge_acc & fifo_full & !pop);
    cycle_inc    = cycle_idx_q + 1'b1;
    if (b_p_clr) begin
      state_d     = S_IDLE;
      road_sel_d  = '0;
      cycle_idx_d = '0;
      seq_d       = '0;
      ovf_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (dianyan_en) begin
          state_d     = S_RUN;
          road_last_d = ROAD_W'(clamp_road(int'(b_p_road_num), ROAD_MAX) - 1);
          cycle_num_d = b_p_cycle_num;
        end
        S_RUN: if (!dianyan_en) begin
          state_d     = S_IDLE;
          road_sel_d  = '0;
          cycle_idx_d = '0;
        end else if (valid_edge_f1) begin
          seq_d = seq_q + 1'b1;
          if (road_sel_q != road_last_q) road_sel_d = road_sel_q + 1'b1;
          else begin
            road_sel_d  = '0;
            cycle_idx_d = cycle_inc;
            if (cycle_num_q != '0 && cycle_inc == cycle_num_q) begin
              cycle_idx_d  = '0;
              batch_done_d = 1'b1;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: if (!dianyan_en) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end
  // control and status registers
  always_ff @(posedge clk_100 or negedge nRST)
    if (!nRST) begin
      state_q      <= S_IDLE;
      road_last_q  <= '0;
      cycle_num_q  <= '0;
      road_sel_q   <= '0;
      cycle_idx_q  <= '0;
      seq_q        <= '0;
      batch_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      road_last_q  <= road_last_d;
      cycle_num_q  <= cycle_num_d;
      road_sel_q   <= road_sel_d;
      cycle_idx_q  <= cycle_idx_d;
      seq_q        <= seq_d;
      batch_done_q <= batch_done_d;
      ovf_q        <= ovf_d;
    end
  // per-road saturating bottle counters
  always_ff @(posedge clk_100 or negedge nRST)
    if (!nRST) begin
      for (int i = 0; i < ROAD_MAX; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < ROAD_MAX; i++)
        if (b_p_clr) cnt_q[i] <= '0;
        else if (edge_acc && road_sel_q == ROAD_W'(i) && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  // counter read mux; addresses beyond ROAD_MAX fall through to 0
  always_comb begin
    cnt_rd_d = '0;
    for (int i = 0; i < ROAD_MAX; i++)
      if (cnt_rd_addr == ROAD_W'(i)) cnt_rd_d = cnt_q[i];
  end
  // registered counter read port
  always_ff @(posedge clk_100 or negedge nRST)
    if (!nRST) cnt_rd_q <= '0;
    else cnt_rd_q <= b_p_clr ? '0 : cnt_rd_d;
  vry_bp_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_100),
    .rst_ni  (nRST),
    .clr_i   (b_p_clr),
    .wr_en_i (push),
    .rd_en_i (pop),
    .din_i   (rec_din),
    .dout_o  (rec_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign {rec_road, rec_cycle, rec_seq} = fifo_empty ? '0 : rec_dout;
  assign rec_valid   = !fifo_empty;
  assign rec_ovf     = ovf_q;
  assign road_sel    = road_sel_q;
  assign cycle_idx   = cycle_idx_q;
  assign batch_done  = batch_done_q;
  assign busy        = state_q == S_RUN;
  assign cnt_rd_data = cnt_rd_q;
endmodule

// File: tb/tb_vry_bottle_print_mc.sv
// tb_vry_bottle_print_mc: directed scoreboard bench for the multi-road bottle tracker
module tb_vry_bottle_print_mc;
  logic        clk_100 = 1'b0, nRST = 1'b0;
  logic        dianyan_en = 0, b_p_clr = 0, valid_edge_f1 = 0, rec_ready = 0;
  logic [7:0]  b_p_road_num = 0, b_p_cycle_num = 0, cnt_rd_addr = 0;
  logic [7:0]  road_sel, cycle_idx, rec_road, rec_cycle;
  logic        batch_done, busy, rec_valid, rec_ovf;
  logic [15:0] rec_seq, cnt_rd_data;
  logic        s_en = 0, s_valid = 0, s_ready = 0;
  logic [7:0]  s_road_num = 0, s_cycle_num = 0, s_rd_addr = 0;
  logic [7:0]  s_road_sel, s_cycle_idx, s_rec_road, s_rec_cycle;
  logic        s_batch_done, s_busy, s_rec_valid, s_rec_ovf;
  logic [3:0]  s_rec_seq, s_cnt_rd_data;
  int          checks = 0, failures = 0;
  logic [31:0] q[$];
  logic [7:0]  m_road, m_cyc, m_rn, m_cn;
  logic [15:0] m_seq;
  logic [15:0] m_cnt [16];
  logic        m_run, m_ovf;

  always #5 clk_100 = ~clk_100;

  vry_bottle_print_mc #(.ROAD_MAX(16), .ROAD_W(8), .CNT_W(16), .FIFO_DEPTH(8)) dut (
    .clk_100(clk_100), .nRST(nRST), .dianyan_en(dianyan_en), .b_p_clr(b_p_clr),
    .valid_edge_f1(valid_edge_f1), .b_p_road_num(b_p_road_num), .b_p_cycle_num(b_p_cycle_num),
    .road_sel(road_sel), .cycle_idx(cycle_idx), .batch_done(batch_done), .busy(busy),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_road(rec_road), .rec_cycle(rec_cycle),
    .rec_seq(rec_seq), .rec_ovf(rec_ovf), .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(cnt_rd_data)
  );

  vry_bottle_print_mc #(.ROAD_MAX(16), .ROAD_W(8), .CNT_W(4), .FIFO_DEPTH(8)) dut_small (
    .clk_100(clk_100), .nRST(nRST), .dianyan_en(s_en), .b_p_clr(1'b0),
    .valid_edge_f1(s_valid), .b_p_road_num(s_road_num), .b_p_cycle_num(s_cycle_num),
    .road_sel(s_road_sel), .cycle_idx(s_cycle_idx), .batch_done(s_batch_done), .busy(s_busy),
    .rec_valid(s_rec_valid), .rec_ready(s_ready), .rec_road(s_rec_road), .rec_cycle(s_rec_cycle),
    .rec_seq(s_rec_seq), .rec_ovf(s_rec_ovf), .cnt_rd_addr(s_rd_addr), .cnt_rd_data(s_cnt_rd_data)
  );

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_road = 0; m_cyc = 0; m_seq = 0; m_run = 0; m_ovf = 0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    q.delete();
  endtask

  task automatic start(input logic [7:0] rn, input logic [7:0] cn);
    b_p_road_num = rn; b_p_cycle_num = cn; dianyan_en = 1;
    step();
    m_rn = rn == 0 ? 8'd1 : (rn > 16 ? 8'd16 : rn);
    m_cn = cn; m_run = 1; m_road = 0; m_cyc = 0;
    chk("busy_start", busy, 1);
  endtask

  task automatic stop();
    dianyan_en = 0;
    step();
    m_run = 0; m_road = 0; m_cyc = 0;
    chk("busy_stop", busy, 0);
    chk("road_stop", road_sel, 0);
    chk("cycle_stop", cycle_idx, 0);
  endtask

  task automatic clear();
    b_p_clr = 1;
    step();
    b_p_clr = 0;
    model_clear();
    chk("clr_valid", rec_valid, 0);
    chk("clr_ovf", rec_ovf, 0);
    chk("clr_road", road_sel, 0);
  endtask

  task automatic bottle();
    logic bd;
    bd = 0;
    valid_edge_f1 = 1;
    if (m_run) begin
      m_seq = m_seq + 1;
      if (m_cnt[m_road] != 16'hffff) m_cnt[m_road] = m_cnt[m_road] + 1;
      if (q.size() < 8) q.push_back({m_road, m_cyc, m_seq});
      else m_ovf = 1;
      if (m_road == m_rn - 1) begin
        m_road = 0;
        m_cyc = m_cyc + 1;
        if (m_cn != 0 && m_cyc == m_cn) begin
          m_cyc = 0; bd = 1; m_run = 0;
        end
      end else m_road = m_road + 1;
    end
    step();
    valid_edge_f1 = 0;
    chk("road_sel", road_sel, m_road);
    chk("cycle_idx", cycle_idx, m_cyc);
    chk("batch_done", batch_done, bd);
    chk("busy", busy, m_run);
    chk("ovf", rec_ovf, m_ovf);
  endtask

  task automatic drain();
    rec_ready = 1;
    for (int n = 0; n < 64 && q.size() > 0; n++) begin
      if (rec_valid) chk("rec", {rec_road, rec_cycle, rec_seq}, q.pop_front());
      step();
    end
    chk("drain_left", 32'(q.size()), 0);
    rec_ready = 0;
    chk("rec_empty", rec_valid, 0);
  endtask

  task automatic rd_cnt(input logic [7:0] a);
    cnt_rd_addr = a;
    step();
    chk("cnt_rd", cnt_rd_data, (a < 16) ? m_cnt[a[3:0]] : 16'd0);
  endtask

  initial begin
    model_clear();
    step();
    step();
    chk("rst_road", road_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rec_valid, 0);
    chk("rst_cnt", cnt_rd_data, 0);
    nRST = 1;
    // batch of two cycles over three roads, then a held edge
    start(3, 2);
    for (int i = 0; i < 7; i++) bottle();
    drain();
    for (int a = 0; a < 3; a++) rd_cnt(8'(a));
    rd_cnt(8'd200);
    stop();
    clear();
    // road_num clamps: 0 -> one road, 40 -> sixteen roads
    start(0, 0);
    for (int i = 0; i < 3; i++) bottle();
    drain();
    stop();
    start(40, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) bottle();
      drain();
    end
    bottle();
    drain();
    stop();
    clear();
    // overflow, then full FIFO with simultaneous pop and push
    start(3, 0);
    for (int i = 0; i < 10; i++) bottle();
    for (int a = 0; a < 3; a++) rd_cnt(8'(a));
    rec_ready = 1;
    chk("head_before_pop", {rec_road, rec_cycle, rec_seq}, q.pop_front());
    bottle();
    rec_ready = 0;
    drain();
    stop();
    clear();
    // clear coincident with an edge mid-batch, then re-latch new config
    start(3, 5);
    bottle();
    bottle();
    b_p_road_num = 2; b_p_cycle_num = 0;
    cnt_rd_addr = 0; valid_edge_f1 = 1; b_p_clr = 1;
    step();
    valid_edge_f1 = 0; b_p_clr = 0;
    model_clear();
    chk("clr_edge_valid", rec_valid, 0);
    chk("clr_edge_busy", busy, 0);
    chk("clr_edge_cnt", cnt_rd_data, 0);
    start(2, 0);
    chk("clr_cnt_t2", cnt_rd_data, 0);
    for (int i = 0; i < 3; i++) bottle();
    drain();
    stop();
    clear();
    // run-enable dropped mid-cycle keeps counters and records
    start(3, 0);
    for (int i = 0; i < 4; i++) bottle();
    stop();
    for (int a = 0; a < 3; a++) rd_cnt(8'(a));
    drain();
    // asynchronous reset mid-run
    start(3, 0);
    cnt_rd_addr = 0;
    bottle();
    bottle();
    dianyan_en = 0;
    #2;
    nRST = 0;
    #1;
    chk("arst_road", road_sel, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", rec_valid, 0);
    chk("arst_seq", rec_seq, 0);
    chk("arst_ovf", rec_ovf, 0);
    chk("arst_cnt", cnt_rd_data, 0);
    step();
    nRST = 1;
    model_clear();
    step();
    chk("arst_after_valid", rec_valid, 0);
    chk("arst_after_busy", busy, 0);
    // narrow counters: saturation and sequence wrap
    s_road_num = 1; s_cycle_num = 0; s_ready = 1; s_en = 1;
    step();
    chk("s_busy", s_busy, 1);
    s_valid = 1;
    for (int i = 0; i < 20; i++) step();
    s_valid = 0;
    chk("s_rec_valid", s_rec_valid, 1);
    chk("s_rec_seq", s_rec_seq, 4);
    chk("s_ovf", s_rec_ovf, 0);
    s_rd_addr = 0;
    step();
    chk("s_cnt_sat", s_cnt_rd_data, 15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vry_bottle_print_mc.md
# vry_bottle_print_mc

Parametrised multi-road bottle-print tracker, the next generation of the bottle-print verification block. Assigns each bottle-arrival pulse round-robin to one of up to ROAD_MAX print roads and counts cycles toward a configurable batch length. It keeps a saturating bottle counter per road and queues one print record per bottle in a FIFO with a ready/valid handshake. Sits between the edge-detect stage (`valid_edge_f1`) and the print-command/logging logic.

## Interface
- ROAD_MAX, 16: number of per-road counters implemented (2..256).
- ROAD_W, 8: width of road-number config and road indices.
- CNT_W, 16: width of per-road counters and sequence number.
- FIFO_DEPTH, 8: record FIFO depth, power of 2.

- clk_100  in  1  system clock, 100 MHz.
- nRST  in  1  asynchronous active-low reset.
- dianyan_en  in  1  run enable; high = tracking active.
- b_p_clr  in  1  synchronous clear: counters, FIFO, ovf, state.
- valid_edge_f1  in  1  single-cycle bottle-arrival pulse.
- b_p_road_num  in  ROAD_W  active road count; 0 → 1, >ROAD_MAX → ROAD_MAX.
- b_p_cycle_num  in  8  cycles per batch; 0 = free-running, no batch end.
- road_sel  out  ROAD_W  road the next bottle is assigned to.
- cycle_idx  out  8  completed cycles in current batch.
- batch_done  out  1  one-cycle pulse at batch completion.
- busy  out  1  high in RUN.
- rec_valid  out  1  FIFO head valid (first-word fall-through).
- rec_ready  in  1  consumer accepts the head record.
- rec_road  out  ROAD_W  head record road.
- rec_cycle  out  8  head record cycle index.
- rec_seq  out  CNT_W  head record global sequence number.
- rec_ovf  out  1  sticky: a record was dropped on a full FIFO.
- cnt_rd_addr  in  ROAD_W  per-road counter read address.
- cnt_rd_data  out  CNT_W  counter value; registered, 1-cycle latency; out-of-range address reads 0.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE → RUN when dianyan_en=1. Clamped b_p_road_num and b_p_cycle_num are latched on this transition. Config changes during RUN/HOLD are ignored.
- RUN, valid_edge_f1=1:
  - counter[road_sel] increments, saturating at all-ones.
  - Global seq increments, wrapping.
  - Record {road_sel, cycle_idx, new seq} is pushed.
  - road_sel advances. On wrap from road_num−1 to 0, cycle_idx increments.
  - If cycle_idx reaches cycle_num (cycle_num≠0): batch_done pulses and the state goes to HOLD. road_sel and cycle_idx then read 0.
- HOLD: edges are ignored (no count, no record). HOLD → IDLE when dianyan_en=0.
- RUN → IDLE when dianyan_en=0. road_sel and cycle_idx reset to 0; counters, seq and FIFO are retained.
- b_p_clr:
  - Highest priority. Clears counters, seq, FIFO, rec_ovf, road_sel and cycle_idx, and forces IDLE.
  - An edge in the same cycle is discarded.
- FIFO full on push: the record is dropped and rec_ovf sets. Counters still update.
  - If the head is popped in the same cycle (full, rec_valid&rec_ready), the push is accepted.
- Reset values: all outputs 0, state IDLE, FIFO empty.

## Timing
- Edge at cycle T → updated road_sel, cycle_idx, counter and seq visible at T+1. batch_done is high only in T+1.
- Empty FIFO: rec_valid rises at T+1 with the record on rec_*. Pop occurs on a cycle with rec_valid&rec_ready; the next head appears the following cycle.
- Back-to-back edges on consecutive cycles are all accepted.
- cnt_rd_data shows counter[addr] as of cycle N at N+1. A same-cycle increment is not visible until N+2.
- b_p_clr at T → all cleared at T+1. With dianyan_en high, RUN is re-entered at T+2 and config is re-latched.
- Asynchronous nRST mid-batch → immediate return to reset values. No partial records remain.

## Structure
- Shared package vry_bp_pkg holds:
  - State encoding (IDLE/RUN/HOLD).
  - Record field layout/width constants.
  - The clamp rule for road_num.
- One sub-module, vry_bp_fifo: synchronous FWFT FIFO with full/empty and simultaneous push/pop, parametrised by width and FIFO_DEPTH.
- Per-road counters are a register array in the top level.

## Test plan
- Config road_num=3, cycle_num=2, dianyan_en=1, 6 edges → records (road,cycle,seq) = (0,0,1)(1,0,2)(2,0,3)(0,1,4)(1,1,5)(2,1,6). batch_done pulses once, the block holds in HOLD, and a 7th edge produces no record.
- road_num=0 and road_num=40 with ROAD_MAX=16 → road_sel stays 0 and cycles over 0..15 respectively.
- rec_ready=0, FIFO_DEPTH=8, 10 edges → 8 records, rec_ovf=1, counter sum 10. Then a full FIFO with rec_ready=1 plus an edge in the same cycle → push accepted, rec_ovf unchanged.
- CNT_W=4, 20 edges on road_num=1 → cnt_rd_data(0)=15 (saturated); rec_seq wraps to 4.
- b_p_clr coincident with an edge mid-batch → no record, all counters 0 at T+1, RUN at T+2 with newly latched config.
- dianyan_en dropped mid-cycle after 4 edges (road_num=3) → road_sel=0, cycle_idx=0, counters {2,1,1} retained. nRST pulse → all outputs 0.
